// File: rtl/fpu_pkg.sv
// Shared constants and FSM state type for the normalisation shift block.
package fpu_pkg;

    localparam int          EMIN_DP = -1022;
    localparam int unsigned SIG_W   = 64;
    localparam int unsigned EXP_W   = 13;
    localparam int unsigned SH_W    = 13;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/lzc16.sv
// 16-bit leading-zero counter; an all-zero input counts as 16.
module lzc16 (
    input  logic [15:0] i_data,
    output logic [4:0]  o_count
);

    // Scan LSB to MSB so the highest set bit writes the final count.
    always_comb begin
        o_count = 5'd16;
        for (int i = 0; i < 16; i++) begin
            if (i_data[i]) begin
                o_count = 5'(15 - i);
            end
        end
    end

endmodule

// File: rtl/norm_shift.sv
// Normalisation shift calculator: counts the leading zeros of a 64-bit significand one
// 16-bit chunk per clock and derives the rounder shift amount, clamped so the result never
// drops below the EMIN normal-range floor.
// Optional macro NORM_SHIFT_EARLY_EXIT_EN: leave SCAN as soon as the leading chunk is found.
module norm_shift
    import fpu_pkg::*;
#(
    parameter int EMIN = EMIN_DP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIG_W-1:0] sig,
    input  logic [EXP_W-1:0] exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SH_W-1:0]  sh,
    output logic [6:0]       lz,
    output logic             zero
);

    state_e           r_state;
    state_e           w_state_next;
    logic [SIG_W-1:0] r_sig;
    logic [EXP_W-1:0] r_exp;
    logic [1:0]       r_idx;
    logic             r_frozen;
    logic [6:0]       r_lz;
    logic [SH_W-1:0]  r_sh;
    logic             r_zero;
    logic             r_out_valid;

    logic [15:0]       w_chunk;
    logic [4:0]        w_chunk_lz;
    logic              w_hit;
    logic              w_finish;
    logic [6:0]        w_lz_next;
    logic              w_zero;
    logic signed [13:0] w_t;
    int                w_diff;
    logic [SH_W-1:0]   w_sat;
    logic [SH_W-1:0]   w_sh;

    assign w_chunk = r_sig[{r_idx, 4'b0000} +: 16];

    lzc16 u_lzc16 (
        .i_data  (w_chunk),
        .o_count (w_chunk_lz)
    );

    // Accumulate chunk counts until the first nonzero chunk, then freeze.
    always_comb begin
        w_hit     = (w_chunk != 16'd0);
        w_lz_next = r_frozen ? r_lz : (r_lz + {2'b00, w_chunk_lz});
        w_zero    = (w_lz_next == 7'd64);
`ifdef NORM_SHIFT_EARLY_EXIT_EN
        w_finish  = (r_idx == 2'd0) || w_hit;
`else
        w_finish  = (r_idx == 2'd0);
`endif
    end

    // Shift amount: full normalise unless that would underflow EMIN, then stop at EMIN.
    always_comb begin
        w_t    = $signed({r_exp[EXP_W-1], r_exp}) - $signed({7'b0000000, w_lz_next});
        w_diff = int'($signed(r_exp)) - EMIN;
        if (w_diff > 4095) begin
            w_sat = 13'h0FFF;
        end else if (w_diff < -4096) begin
            w_sat = 13'h1000;
        end else begin
            w_sat = w_diff[SH_W-1:0];
        end
        if (w_zero) begin
            w_sh = '0;
        end else if (int'(w_t) >= EMIN) begin
            w_sh = {6'b000000, w_lz_next};
        end else begin
            w_sh = w_sat;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (in_valid)  w_state_next = StScan;
            StScan:  if (w_finish)  w_state_next = StDone;
            StDone:  if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State, operand capture, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_sig       <= '0;
            r_exp       <= '0;
            r_idx       <= 2'd0;
            r_frozen    <= 1'b0;
            r_lz        <= 7'd0;
            r_sh        <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_sig    <= sig;
                        r_exp    <= exp;
                        r_lz     <= 7'd0;
                        r_idx    <= 2'd3;
                        r_frozen <= 1'b0;
                    end
                end
                StScan: begin
                    r_lz     <= w_lz_next;
                    r_frozen <= r_frozen | w_hit;
                    r_idx    <= r_idx - 2'd1;
                    if (w_finish) begin
                        r_out_valid <= 1'b1;
                        r_sh        <= w_sh;
                        r_zero      <= w_zero;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = r_out_valid;
    assign sh        = r_sh;
    assign lz        = r_lz;
    assign zero      = r_zero;

endmodule

// File: tb/tb_norm_shift.sv
// Self-checking bench for norm_shift against a bit-serial reference model.
module tb_norm_shift;

    localparam int EMIN = -1022;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] sig;
    logic [12:0] exp;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] sh;
    logic [6:0]  lz;
    logic        zero;

    int checks;
    int errors;

    norm_shift #(
        .EMIN (EMIN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sig       (sig),
        .exp       (exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sh        (sh),
        .lz        (lz),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: leading zeros by walking bits from the MSB.
    function automatic int ref_lz(input logic [63:0] s);
        for (int i = 63; i >= 0; i--) begin
            if (s[i]) return 63 - i;
        end
        return 64;
    endfunction

    function automatic logic [12:0] ref_sh(input logic [63:0] s, input logic [12:0] e_bits);
        int e;
        int l;
        int d;
        logic [31:0] dv;
        e = int'($signed(e_bits));
        l = ref_lz(s);
        if (l == 64) return 13'd0;
        if (e - l >= EMIN) return 13'(l);
        d = e - EMIN;
        if (d > 4095) d = 4095;
        if (d < -4096) d = -4096;
        dv = d;
        return dv[12:0];
    endfunction

    function automatic int ref_lat(input logic [63:0] s);
`ifdef NORM_SHIFT_EARLY_EXIT_EN
        int l;
        l = ref_lz(s);
        if (l == 64) return 4;
        return l / 16 + 1;
`else
        return 4;
`endif
    endfunction

    // Drive one operand from IDLE, wait for out_valid, capture outputs, then hand it off.
    task automatic do_op(input logic [63:0] s, input logic [12:0] e, output int lat,
                         output logic [12:0] o_sh, output logic [6:0] o_lz, output logic o_zero);
        in_valid = 1'b1;
        sig      = s;
        exp      = e;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sig      = '0;
        exp      = '0;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        o_sh   = sh;
        o_lz   = lz;
        o_zero = zero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sig = '0;
        exp = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({in_ready, out_valid, sh, lz, zero} !== {1'b1, 1'b0, 13'd0, 7'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b ov=%b sh=%h lz=%0d z=%b want 1 0 0 0 0",
                     in_ready, out_valid, sh, lz, zero);
        end
    endtask

    task automatic test_directed();
        logic [63:0] s_tab [5] = '{64'h8000_0000_0000_0000, 64'd1, 64'd1,
                                   64'h8000_0000_0000_0000, 64'd0};
        int          e_tab [5] = '{0, 100, -1000, -1030, 5};
        logic [12:0] sh_w  [5] = '{13'd0, 13'd63, 13'd22, 13'h1FF8, 13'd0};
        logic [6:0]  lz_w  [5] = '{7'd0, 7'd63, 7'd63, 7'd0, 7'd64};
        logic        z_w   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        logic [12:0] g_sh;
        logic [6:0]  g_lz;
        logic        g_z;
        int          ev;
        logic [12:0] eb;
        for (int i = 0; i < 5; i++) begin
            ev = e_tab[i];
            eb = ev[12:0];
            do_op(s_tab[i], eb, lat, g_sh, g_lz, g_z);
            checks++;
            if (g_lz !== lz_w[i] || g_sh !== sh_w[i] || g_z !== z_w[i]) begin
                errors++;
                $display("FAIL directed_%0d: got lz=%0d sh=%h z=%b want lz=%0d sh=%h z=%b",
                         i, g_lz, g_sh, g_z, lz_w[i], sh_w[i], z_w[i]);
            end
            checks++;
            if (lat != ref_lat(s_tab[i])) begin
                errors++;
                $display("FAIL directed_lat_%0d: got %0d want %0d", i, lat, ref_lat(s_tab[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] s;
        logic [12:0] e;
        int          ev;
        int lat;
        logic [12:0] g_sh;
        logic [6:0]  g_lz;
        logic        g_z;
        for (int n = 0; n < 60; n++) begin
            s = {$urandom, $urandom};
            s = s >> $urandom_range(0, 64);
            if ($urandom_range(0, 1) == 1) begin
                ev = EMIN + int'($urandom_range(0, 160)) - 80;
            end else begin
                ev = int'($urandom_range(0, 8191)) - 4096;
            end
            e = ev[12:0];
            do_op(s, e, lat, g_sh, g_lz, g_z);
            checks++;
            if (g_lz !== 7'(ref_lz(s)) || g_sh !== ref_sh(s, e) ||
                g_z !== (ref_lz(s) == 64)) begin
                errors++;
                $display("FAIL random_%0d sig=%h exp=%h: got lz=%0d sh=%h z=%b want lz=%0d sh=%h",
                         n, s, e, g_lz, g_sh, g_z, ref_lz(s), ref_sh(s, e));
            end
            checks++;
            if (lat != ref_lat(s)) begin
                errors++;
                $display("FAIL random_lat_%0d: got %0d want %0d", n, lat, ref_lat(s));
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [63:0] s1 = 64'h0000_0F00_0000_0000;
        logic [63:0] s2 = 64'h0000_0000_0000_0100;
        logic [12:0] e1 = 13'd7;
        logic [12:0] e2 = 13'd300;
        int wait_cnt;
        int lat;
        logic [12:0] g_sh;
        logic [6:0]  g_lz;
        logic        g_z;
        in_valid = 1'b1;
        sig = s1;
        exp = e1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        // Competing operand held on the inputs while the result waits.
        in_valid = 1'b1;
        sig = s2;
        exp = e2;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || lz !== 7'(ref_lz(s1)) ||
                sh !== ref_sh(s1, e1) || zero !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: got ov=%b rdy=%b lz=%0d sh=%h want 1 0 %0d %h",
                         c, out_valid, in_ready, lz, sh, ref_lz(s1), ref_sh(s1, e1));
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handoff: got ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        do_op(s2, e2, lat, g_sh, g_lz, g_z);
        checks++;
        if (g_lz !== 7'(ref_lz(s2)) || g_sh !== ref_sh(s2, e2) || lat != ref_lat(s2)) begin
            errors++;
            $display("FAIL after_hold: got lz=%0d sh=%h lat=%0d want %0d %h %0d",
                     g_lz, g_sh, lat, ref_lz(s2), ref_sh(s2, e2), ref_lat(s2));
        end
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        int lat;
        logic [12:0] g_sh;
        logic [6:0]  g_lz;
        logic        g_z;
        in_valid = 1'b1;
        sig = 64'd3;
        exp = 13'd50;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({in_ready, out_valid, sh, lz, zero} !== {1'b1, 1'b0, 13'd0, 7'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_scan: got rdy=%b ov=%b sh=%h lz=%0d z=%b want 1 0 0 0 0",
                     in_ready, out_valid, sh, lz, zero);
        end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL stale_result: got %0d valid cycles want 0", seen);
        end
        do_op(64'h0000_8000_0000_0000, 13'd20, lat, g_sh, g_lz, g_z);
        checks++;
        if (g_lz !== 7'd16 || g_sh !== 13'd16 || g_z !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_op: got lz=%0d sh=%h z=%b want 16 0010 0",
                     g_lz, g_sh, g_z);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_back_pressure();
        test_reset_mid_scan();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/norm_shift.md
NORM_SHIFT -- requirements
Module: norm_shift

Interface
REQ-001 SHALL have parameter EMIN, default -1022, meaning the minimum unbiased exponent (normal range floor).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, operand present.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand.
REQ-006 SHALL have port sig, input, 64, unnormalized significand.
REQ-007 SHALL have port exp, input, 13, signed two's-complement unbiased exponent.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port sh, output, 13, signed shift amount for the rounder mask (positive: left shift; negative: right shift).
REQ-011 SHALL have port lz, output, 7, leading-zero count of sig, 0..64.
REQ-012 SHALL have port zero, output, 1, sig was all-zero.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SCAN, DONE.
REQ-014 SHALL drive in_ready = 1 exactly when the state is IDLE.
REQ-015 On an edge with in_valid & in_ready, SHALL latch sig and exp, clear the lz accumulator, set the chunk index to 3, and enter SCAN.
REQ-016 In SCAN, SHALL examine one 16-bit chunk per edge, MSB chunk (sig[63:48]) first, down to chunk 0.
REQ-017 For each all-zero chunk, SHALL add 16 to lz and decrement the chunk index.
REQ-018 At the first nonzero chunk, SHALL add that chunk's leading-zero count to lz and freeze the accumulator.
REQ-019 After the chunk-0 edge, SHALL enter DONE with out_valid = 1.
REQ-020 Without early exit, total latency SHALL be 4 edges from acceptance to out_valid, independent of data.
REQ-021 SHALL compute t = exp - lz using 14-bit signed arithmetic.
REQ-022 If t >= EMIN, SHALL set sh = lz.
REQ-023 If t < EMIN, SHALL set sh = exp - EMIN, saturated to the 13-bit signed range [-4096, 4095].
REQ-024 For an all-zero sig, SHALL set lz = 64, zero = 1 and sh = 0.
REQ-025 In DONE, sh, lz, zero and out_valid SHALL hold stable until out_ready = 1.
REQ-026 On the edge with out_ready = 1, SHALL drop out_valid and return to IDLE; the next operand is accepted one cycle later (no same-edge overlap).
REQ-027 in_valid asserted outside IDLE SHALL be ignored.
REQ-028 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-029 On a clk edge with rst_n = 0, SHALL set state = IDLE, out_valid = 0, sh = 0, lz = 0, zero = 0; in_ready reads 1 from the following cycle.
REQ-030 Reset asserted during SCAN or DONE SHALL abort the operation and discard the operand with no output produced.

Configuration
REQ-031 With macro NORM_SHIFT_EARLY_EXIT_EN defined, SHALL go from SCAN directly to DONE on the edge that finds the first nonzero chunk, giving 1-4 edges of latency (4 for zero or chunk-0 leaders).
REQ-032 Without NORM_SHIFT_EARLY_EXIT_EN, SHALL always scan 4 chunks (fixed latency), with identical outputs.

Structure
REQ-033 Package fpu_pkg SHALL hold EMIN_DP, the widths SIG_W = 64, EXP_W = 13 and SH_W = 13, and the FSM state enum typedef.
REQ-034 SHALL instantiate one combinational sub-module lzc16 (16-bit input, 5-bit count, 16 for all-zero).

Verification
REQ-035 Scenario: sig = 64'h8000_0000_0000_0000, exp = 0 -> lz = 0, sh = 0, zero = 0; out_valid 4 edges after acceptance (1 with early exit).
REQ-036 Scenario: sig = 1, exp = 100 -> lz = 63, sh = 63, latency 4.
REQ-037 Scenario: sig = 1, exp = -1000, EMIN = -1022 -> lz = 63, sh = 22; sig = 64'h8000_0000_0000_0000, exp = -1030 -> sh = -8 (13'h1FF8).
REQ-038 Scenario: sig = 0, exp = 5 -> lz = 64, zero = 1, sh = 0.
REQ-039 Scenario: hold out_ready = 0 for 3 cycles in DONE -> outputs stable and in_ready = 0; a competing in_valid is ignored; handshake on cycle 4 -> IDLE, next operand accepted one cycle later.
REQ-040 Scenario: rst_n = 0 for one edge during SCAN -> IDLE, out_valid stays 0, in_ready = 1 the next cycle, no stale result ever appears.
